// File: rtl/pipe_stage_reg.sv
// Y86-64 inter-stage pipeline register carrying stat, icode and a generic payload.
// Latency: 1 cycle from input to output; no combinational input-to-output path.
// Backpressure: stall holds contents, bubble loads a NOP, optional sticky freeze on bad stat.
module pipe_stage_reg #(
    parameter int unsigned               PAYLOAD_W      = 201,
    parameter int unsigned               STAT_W         = 3,
    parameter int unsigned               ICODE_W        = 4,
    parameter logic [ICODE_W-1:0]        NOP_ICODE      = 4'h1,
    parameter logic [STAT_W-1:0]         SAOK           = 3'd1,
    parameter logic [PAYLOAD_W-1:0]      BUBBLE_PAYLOAD = '0,
    parameter bit                        FREEZE_ON_EXC  = 1'b0,
    parameter int unsigned               CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 bubble,
    input  logic [STAT_W-1:0]    in_stat,
    input  logic [ICODE_W-1:0]   in_icode,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic [STAT_W-1:0]    out_stat,
    output logic [ICODE_W-1:0]   out_icode,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_valid,
    output logic                 frozen,
    output logic                 ctrl_err,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_stat    <= SAOK;
            out_icode   <= NOP_ICODE;
            out_payload <= BUBBLE_PAYLOAD;
            out_valid   <= 1'b0;
            frozen      <= 1'b0;
            ctrl_err    <= 1'b0;
            stall_cnt   <= '0;
            bubble_cnt  <= '0;
        end else if (frozen) begin
            // Everything holds until reset; stall/bubble are ignored here.
            out_stat <= out_stat;
        end else if (stall) begin
            if (stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (bubble) begin
                ctrl_err <= 1'b1;
            end
        end else if (bubble) begin
            out_stat    <= SAOK;
            out_icode   <= NOP_ICODE;
            out_payload <= BUBBLE_PAYLOAD;
            out_valid   <= 1'b0;
            if (bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end else begin
            out_stat    <= in_stat;
            out_icode   <= in_icode;
            out_payload <= in_payload;
            out_valid   <= 1'b1;
            // Only a real load of a bad stat freezes; the bad value itself is kept.
            if (FREEZE_ON_EXC && (in_stat != SAOK)) begin
                frozen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: one freezing instance with 4-bit counters, one default non-freezing instance.
module tb_pipe_stage_reg;

    localparam int unsigned PW = 32;

    logic          clk = 1'b0;
    logic          rst, stall, bubble;
    logic [2:0]    in_stat;
    logic [3:0]    in_icode;
    logic [PW-1:0] in_payload;

    logic [2:0]    a_stat, b_stat;
    logic [3:0]    a_icode, b_icode;
    logic [PW-1:0] a_payload, b_payload;
    logic          a_valid, b_valid, a_frozen, b_frozen, a_err, b_err;
    logic [3:0]    a_scnt, a_bcnt;
    logic [15:0]   b_scnt, b_bcnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.PAYLOAD_W(PW), .FREEZE_ON_EXC(1'b1), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
        .in_stat(in_stat), .in_icode(in_icode), .in_payload(in_payload),
        .out_stat(a_stat), .out_icode(a_icode), .out_payload(a_payload),
        .out_valid(a_valid), .frozen(a_frozen), .ctrl_err(a_err),
        .stall_cnt(a_scnt), .bubble_cnt(a_bcnt)
    );

    pipe_stage_reg #(.PAYLOAD_W(PW)) u_b (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
        .in_stat(in_stat), .in_icode(in_icode), .in_payload(in_payload),
        .out_stat(b_stat), .out_icode(b_icode), .out_payload(b_payload),
        .out_valid(b_valid), .frozen(b_frozen), .ctrl_err(b_err),
        .stall_cnt(b_scnt), .bubble_cnt(b_bcnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [2:0] s, input logic [3:0] ic, input logic [PW-1:0] p);
        in_stat    = s;
        in_icode   = ic;
        in_payload = p;
    endtask

    initial begin
        // Reset with random inputs and random control
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            stall  = 1'($urandom_range(0, 1));
            bubble = 1'($urandom_range(0, 1));
            load(3'($urandom), 4'($urandom), PW'($urandom));
            tick();
        end
        chk("rst_stat", 64'(a_stat), 64'd1);
        chk("rst_icode", 64'(a_icode), 64'd1);
        chk("rst_payload", 64'(a_payload), 64'd0);
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_frozen", 64'(a_frozen), 64'd0);
        chk("rst_err", 64'(a_err), 64'd0);
        chk("rst_scnt", 64'(a_scnt), 64'd0);
        chk("rst_bcnt", 64'(a_bcnt), 64'd0);

        // Pass-through
        rst = 1'b0; stall = 1'b0; bubble = 1'b0;
        load(3'd1, 4'd2, 32'hA000_0002); tick();
        chk("pt_icode2", 64'(a_icode), 64'd2);
        chk("pt_pay2", 64'(a_payload), 64'hA000_0002);
        chk("pt_valid2", 64'(a_valid), 64'd1);
        load(3'd1, 4'd3, 32'hB000_0003); tick();
        chk("pt_icode3", 64'(a_icode), 64'd3);
        chk("pt_pay3", 64'(a_payload), 64'hB000_0003);
        load(3'd1, 4'd4, 32'hC000_0004); tick();
        chk("pt_icode4", 64'(a_icode), 64'd4);
        chk("pt_pay4", 64'(a_payload), 64'hC000_0004);
        chk("pt_stat4", 64'(a_stat), 64'd1);

        // Stall
        load(3'd1, 4'd6, 32'h0000_0066); tick();
        chk("st_load6", 64'(a_icode), 64'd6);
        stall = 1'b1;
        load(3'd1, 4'd7, 32'h0000_0077);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_hold_icode", 64'(a_icode), 64'd6);
            chk("st_hold_pay", 64'(a_payload), 64'h66);
        end
        stall = 1'b0; tick();
        chk("st_release", 64'(a_icode), 64'd7);
        chk("st_cnt_a", 64'(a_scnt), 64'd3);
        chk("st_cnt_b", 64'(b_scnt), 64'd3);

        // Bubble
        bubble = 1'b1; tick();
        chk("bb_icode", 64'(a_icode), 64'd1);
        chk("bb_valid", 64'(a_valid), 64'd0);
        chk("bb_pay", 64'(a_payload), 64'd0);
        chk("bb_stat", 64'(a_stat), 64'd1);
        chk("bb_cnt", 64'(a_bcnt), 64'd1);

        // Conflict: stall and bubble together
        bubble = 1'b0;
        load(3'd1, 4'd8, 32'h0000_0088); tick();
        chk("cf_load8", 64'(a_icode), 64'd8);
        stall = 1'b1; bubble = 1'b1;
        load(3'd1, 4'd9, 32'h0000_0099); tick();
        chk("cf_hold_icode", 64'(a_icode), 64'd8);
        chk("cf_hold_valid", 64'(a_valid), 64'd1);
        chk("cf_err", 64'(a_err), 64'd1);
        chk("cf_bcnt", 64'(a_bcnt), 64'd1);
        chk("cf_scnt", 64'(a_scnt), 64'd4);
        stall = 1'b0; bubble = 1'b0;
        load(3'd1, 4'hA, 32'h0000_00AA); tick();
        chk("cf_loadA", 64'(a_icode), 64'hA);
        chk("cf_err_sticky", 64'(a_err), 64'd1);

        // Freeze on exceptional stat
        load(3'd3, 4'd5, 32'h0000_0055); tick();
        chk("fz_stat_a", 64'(a_stat), 64'd3);
        chk("fz_icode_a", 64'(a_icode), 64'd5);
        chk("fz_frozen_a", 64'(a_frozen), 64'd1);
        chk("fz_stat_b", 64'(b_stat), 64'd3);
        chk("fz_frozen_b", 64'(b_frozen), 64'd0);
        load(3'd1, 4'd2, 32'h0000_0022); tick();
        chk("fz_hold_icode", 64'(a_icode), 64'd5);
        chk("fz_hold_stat", 64'(a_stat), 64'd3);
        chk("fz_b_loads", 64'(b_icode), 64'd2);
        bubble = 1'b1; tick();
        chk("fz_bb_icode", 64'(a_icode), 64'd5);
        chk("fz_bb_valid", 64'(a_valid), 64'd1);
        chk("fz_bb_cnt_a", 64'(a_bcnt), 64'd1);
        chk("fz_bb_cnt_b", 64'(b_bcnt), 64'd2);
        bubble = 1'b0; stall = 1'b1; tick();
        chk("fz_st_cnt_a", 64'(a_scnt), 64'd4);
        chk("fz_st_cnt_b", 64'(b_scnt), 64'd5);

        // Reset out of freeze, mid-stall
        rst = 1'b1; tick();
        chk("fr_stat", 64'(a_stat), 64'd1);
        chk("fr_icode", 64'(a_icode), 64'd1);
        chk("fr_payload", 64'(a_payload), 64'd0);
        chk("fr_valid", 64'(a_valid), 64'd0);
        chk("fr_frozen", 64'(a_frozen), 64'd0);
        chk("fr_err", 64'(a_err), 64'd0);
        chk("fr_scnt", 64'(a_scnt), 64'd0);
        chk("fr_bcnt", 64'(a_bcnt), 64'd0);
        rst = 1'b0; stall = 1'b0;
        load(3'd1, 4'd3, 32'h0000_0033); tick();
        chk("fr_load_after", 64'(a_icode), 64'd3);
        chk("fr_valid_after", 64'(a_valid), 64'd1);

        // Saturation of 4-bit counters
        stall = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("sat_scnt", 64'(a_scnt), (i > 15) ? 64'd15 : 64'(i));
        end
        chk("sat_scnt_b", 64'(b_scnt), 64'd20);
        stall = 1'b0; bubble = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
        end
        chk("sat_bcnt_a", 64'(a_bcnt), 64'd15);
        chk("sat_bcnt_b", 64'(b_bcnt), 64'd17);
        chk("sat_err_clear", 64'(a_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
